// File: rtl/sw_step_conditioner_pkg.sv
// sw_step_conditioner_pkg: shared FSM encodings and synchroniser idle levels
package sw_step_conditioner_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
  localparam logic SW_IDLE  = 1'b0;
  localparam logic BTN_IDLE = 1'b1;
endpackage

// File: rtl/sw_step_conditioner_debounce_filter.sv
// sw_step_conditioner_debounce_filter: two-flop synchroniser plus stability counter
module sw_step_conditioner_debounce_filter #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE_LVL        = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_in;
  // idle raw level always maps to a filtered 0, so the button path comes out active-high
  assign w_in    = r_s2 ^ IDLE_LVL;
  assign o_level = r_level;
  // plain two-flop synchroniser, resetting to the input's idle level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1 <= IDLE_LVL;
      r_s2 <= IDLE_LVL;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end
  // count consecutive disagreeing samples; flip the level once the run is long enough
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_in == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= w_in;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sw_step_conditioner.sv
// sw_step_conditioner: debounced mode level and step pulses with auto-repeat
module sw_step_conditioner
  import sw_step_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_M,
  input  logic BTN_N,
  output logic M,
  output logic STEP,
  output logic PRESSED
);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);
  logic          w_m;
  logic          w_pressed;
  state_t        r_state;
  state_t        w_state_nx;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nx;
  logic          r_step;
  logic          w_step_nx;
  sw_step_conditioner_debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LVL       (SW_IDLE)
  ) u_sw (
    .CLK    (CLK),
    .RST    (RST),
    .i_raw  (SW_M),
    .o_level(w_m)
  );
  sw_step_conditioner_debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LVL       (BTN_IDLE)
  ) u_btn (
    .CLK    (CLK),
    .RST    (RST),
    .i_raw  (BTN_N),
    .o_level(w_pressed)
  );
  assign M       = w_m;
  assign PRESSED = w_pressed;
  assign STEP    = r_step;
  // button FSM: first step on press, hold delay, then periodic repeats sharing one timer
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_step_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pressed) begin
          w_step_nx  = 1'b1;
          w_tmr_nx   = HOLD_LOAD;
          w_state_nx = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!w_pressed) begin
          w_state_nx = ST_IDLE;
        end else if (r_tmr == '0) begin
          if (REPEAT_EN != 0) begin
            w_step_nx  = 1'b1;
            w_tmr_nx   = REPEAT_LOAD;
            w_state_nx = ST_REPEAT;
          end
        end else begin
          w_tmr_nx = r_tmr - TW'(1);
        end
      end
      ST_REPEAT: begin
        if (!w_pressed) begin
          w_state_nx = ST_IDLE;
        end else if (r_tmr == '0) begin
          w_step_nx = 1'b1;
          w_tmr_nx  = REPEAT_LOAD;
        end else begin
          w_tmr_nx = r_tmr - TW'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end
  // FSM, timer and registered step pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tmr   <= w_tmr_nx;
      r_step  <= w_step_nx;
    end
  end
endmodule

// File: tb/tb_sw_step_conditioner.sv
// tb_sw_step_conditioner: scenario tasks checked against an edge-level behavioural model
module tb_sw_step_conditioner;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  logic CLK   = 1'b0;
  logic RST   = 1'b1;
  logic SW_M  = 1'b0;
  logic BTN_N = 1'b1;
  logic m1, s1, p1, m0, s0, p0;
  int checks = 0;
  int errors = 0;
  logic q_sw[$];
  logic q_bt[$];
  logic e_m, e_p, e_s1, e_s0;
  int run_sw, run_bt, age;

  sw_step_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1)) u_rep (
    .CLK(CLK), .RST(RST), .SW_M(SW_M), .BTN_N(BTN_N), .M(m1), .STEP(s1), .PRESSED(p1));
  sw_step_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(0)) u_one (
    .CLK(CLK), .RST(RST), .SW_M(SW_M), .BTN_N(BTN_N), .M(m0), .STEP(s0), .PRESSED(p0));

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    q_sw = {1'b0, 1'b0};
    q_bt = {1'b1, 1'b1};
    e_m = 1'b0; e_p = 1'b0; e_s1 = 1'b0; e_s0 = 1'b0;
    run_sw = 0; run_bt = 0; age = 0;
  endfunction

  // filters see the raw value from two edges back; steps follow from edges elapsed since the press
  function automatic void model_edge();
    logic sw_d, bt_d, p_new;
    int a;
    q_sw.push_front(SW_M);
    q_bt.push_front(BTN_N);
    sw_d = q_sw.pop_back();
    bt_d = !q_bt.pop_back();
    a = age + 1;
    e_s1 = e_p && (a == 1 || (a > H && (a - H - 1) % R == 0));
    e_s0 = e_p && (a == 1);
    run_sw = (sw_d == e_m) ? 0 : run_sw + 1;
    if (run_sw == D) begin e_m = sw_d; run_sw = 0; end
    run_bt = (bt_d == e_p) ? 0 : run_bt + 1;
    p_new = e_p;
    if (run_bt == D) begin p_new = bt_d; run_bt = 0; end
    age = (p_new && e_p) ? a : 0;
    e_p = p_new;
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (!RST) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 RST = 1'b0;
    #1;
    checks++;
    if ({m1, s1, p1, m0, s0, p0} !== 6'b0) begin
      errors++; $display("FAIL reset_async: got %b want 000000", {m1, s1, p1, m0, s0, p0});
    end
    model_reset();
    tick(); tick();
    checks++;
    if ({m1, s1, p1, m0, s0, p0} !== 6'b0) begin
      errors++; $display("FAIL reset_held: got %b want 000000", {m1, s1, p1, m0, s0, p0});
    end
    RST = 1'b1;
  endtask

  task automatic test_mode();
    int n = 0;
    SW_M = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({m1, s1, m0, s0} !== {e_m, 1'b0, e_m, 1'b0}) begin
        errors++; $display("FAIL mode_cycle%0d: got %b want %b", i, {m1, s1, m0, s0}, {e_m, 1'b0, e_m, 1'b0});
      end
      if (m1 && n == 0) n = i;
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL mode_latency: got %0d want 6", n); end
  endtask

  task automatic test_glitch();
    int n = 0;
    int len = $urandom_range(1, 3);
    SW_M = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (m1 !== 1'b0) begin errors++; $display("FAIL glitch_settle: got %b want 0", m1); end
    SW_M = 1'b1;
    for (int i = 0; i < len; i++) tick();
    SW_M = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (m1 !== 1'b0 || e_m !== 1'b0) begin
        errors++; $display("FAIL glitch_len%0d: got %b model %b want 0", len, m1, e_m);
      end
    end
    SW_M = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (m1 && n == 0) n = i;
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL glitch_then_stable: got %0d want 6", n); end
  endtask

  task automatic test_press_release();
    int rise = 0, fall = 0, nstep = 0, at = 0;
    for (int i = 1; i <= 30; i++) begin
      BTN_N = (i <= 10) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({p1, s1, p0, s0} !== {e_p, e_s1, e_p, e_s0}) begin
        errors++; $display("FAIL press_cycle%0d: got %b want %b", i, {p1, s1, p0, s0}, {e_p, e_s1, e_p, e_s0});
      end
      if (p1 && rise == 0) rise = i;
      if (!p1 && rise != 0 && fall == 0) fall = i;
      if (s1) begin nstep++; at = i; end
    end
    checks++;
    if (rise != 6 || fall != 16) begin
      errors++; $display("FAIL press_levels: got rise %0d fall %0d want 6 16", rise, fall);
    end
    checks++;
    if (nstep != 1 || at != 7) begin
      errors++; $display("FAIL press_step: got %0d steps at %0d want 1 at 7", nstep, at);
    end
  endtask

  task automatic test_hold_repeat();
    int got1[$];
    int got0[$];
    int want1[$] = '{7, 27, 35, 43, 51, 59};
    for (int i = 1; i <= 80; i++) begin
      BTN_N = (i <= 60) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({p1, s1, p0, s0} !== {e_p, e_s1, e_p, e_s0}) begin
        errors++; $display("FAIL hold_cycle%0d: got %b want %b", i, {p1, s1, p0, s0}, {e_p, e_s1, e_p, e_s0});
      end
      if (s1) got1.push_back(i);
      if (s0) got0.push_back(i);
    end
    checks++;
    if (got1 != want1) begin
      errors++; $display("FAIL hold_repeat_times: got %p want %p", got1, want1);
    end
    checks++;
    if (got0.size() != 1 || (got0.size() == 1 && got0[0] != 7)) begin
      errors++; $display("FAIL hold_single_step: got %p want '{7}", got0);
    end
  endtask

  task automatic test_reset_mid();
    int rise = 0, at = 0, nstep = 0;
    BTN_N = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({p1, s1} !== {e_p, e_s1}) begin
        errors++; $display("FAIL mid_pre_cycle%0d: got %b want %b", i, {p1, s1}, {e_p, e_s1});
      end
    end
    RST = 1'b0;
    #2;
    checks++;
    if ({m1, s1, p1, m0, s0, p0} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_async: got %b want 000000", {m1, s1, p1, m0, s0, p0});
    end
    tick();
    RST = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks++;
      if ({m1, p1, s1, s0} !== {e_m, e_p, e_s1, e_s0}) begin
        errors++; $display("FAIL mid_post_cycle%0d: got %b want %b", i, {m1, p1, s1, s0}, {e_m, e_p, e_s1, e_s0});
      end
      if (p1 && rise == 0) rise = i;
      if (s1) begin nstep++; at = i; end
    end
    checks++;
    if (rise != 6 || nstep != 1 || at != 7) begin
      errors++; $display("FAIL mid_requalify: got rise %0d steps %0d at %0d want 6 1 7", rise, nstep, at);
    end
    BTN_N = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_simultaneous();
    int mr = 0, pr = 0, nstep = 0, at = 0;
    SW_M = 1'b0;
    BTN_N = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    SW_M = 1'b1;
    BTN_N = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks++;
      if ({m1, p1, s1, m0, p0, s0} !== {e_m, e_p, e_s1, e_m, e_p, e_s0}) begin
        errors++; $display("FAIL simul_cycle%0d: got %b want %b", i, {m1, p1, s1, m0, p0, s0}, {e_m, e_p, e_s1, e_m, e_p, e_s0});
      end
      if (m1 && mr == 0) mr = i;
      if (p1 && pr == 0) pr = i;
      if (s1) begin nstep++; at = i; end
    end
    checks++;
    if (mr != 6 || pr != 6 || nstep != 1 || at != 7) begin
      errors++; $display("FAIL simul_timing: got m %0d p %0d steps %0d at %0d want 6 6 1 7", mr, pr, nstep, at);
    end
    BTN_N = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_random();
    int sw_left = 0, bt_left = 0, bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if (sw_left == 0) begin SW_M = $urandom_range(0, 1); sw_left = $urandom_range(1, 12); end
      if (bt_left == 0) begin BTN_N = $urandom_range(0, 1); bt_left = $urandom_range(1, 60); end
      sw_left--;
      bt_left--;
      tick();
      checks++;
      if ({m1, p1, s1, m0, p0, s0} !== {e_m, e_p, e_s1, e_m, e_p, e_s0}) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle%0d: got %b want %b", i, {m1, p1, s1, m0, p0, s0}, {e_m, e_p, e_s1, e_m, e_p, e_s0});
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode();
    test_glitch();
    test_press_release();
    test_hold_repeat();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
